// File: rtl/alu_logic_shift.sv
// Logic/shift ALU: single-cycle bitwise ops, shifts and rotates done one bit per clock.
// Results, zero and err are registered and held until the next completion.
module alu_logic_shift #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             err
);

  localparam logic StIdle  = 1'b0;
  localparam logic StShift = 1'b1;

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpNot  = 4'd2;
  localparam logic [3:0] OpNeg  = 4'd3;
  localparam logic [3:0] OpShl  = 4'd4;
  localparam logic [3:0] OpShr  = 4'd5;
  localparam logic [3:0] OpShra = 4'd6;
  localparam logic [3:0] OpRol  = 4'd7;
  localparam logic [3:0] OpRor  = 4'd8;

  logic               state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   shifted;
  logic               complete;
  logic               unused_b;

  assign shamt    = b[SHAMT_W-1:0];
  assign unused_b = ^b[WIDTH-1:SHAMT_W];

  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] sel,
                                                 input logic [WIDTH-1:0] v);
    case (sel)
      OpShl:   return {v[WIDTH-2:0], 1'b0};
      OpShr:   return {1'b0, v[WIDTH-1:1]};
      OpShra:  return {v[WIDTH-1], v[WIDTH-1:1]};
      OpRol:   return {v[WIDTH-2:0], v[WIDTH-1]};
      OpRor:   return {v[0], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    c_d      = c_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
    result   = '0;
    shifted  = '0;
    complete = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpAnd: begin result = a & b; complete = 1'b1; end
            OpOr:  begin result = a | b; complete = 1'b1; end
            OpNot: begin result = ~a;    complete = 1'b1; end
            OpNeg: begin result = '0 - a; complete = 1'b1; end
            OpShl, OpShr, OpShra, OpRol, OpRor: begin
              // The start edge already performs the first one-bit step, so a
              // shift by k completes on edge k-1 after start (latency k).
              shifted = shift_one(op, a);
              if (shamt == '0) begin
                result   = a;
                complete = 1'b1;
              end else if (shamt == SHAMT_W'(1)) begin
                result   = shifted;
                complete = 1'b1;
              end else begin
                work_d  = shifted;
                cnt_d   = shamt - SHAMT_W'(1);
                op_d    = op;
                state_d = StShift;
              end
            end
            default: begin
              c_d    = '0;
              zero_d = 1'b1;
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          endcase
        end
      end
      default: begin
        shifted = shift_one(op_q, work_q);
        work_d  = shifted;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result   = shifted;
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
    endcase

    if (complete) begin
      c_d    = result;
      zero_d = (result == '0);
      err_d  = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      c_q     <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign c    = c_q;
  assign zero = zero_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q == StShift);

endmodule

// File: doc/alu_logic_shift.md
ALU_LOGIC_SHIFT -- requirements
Module: alu_logic_shift

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal values: powers of two, 8 to 64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount field width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request strobe, sampled on rising clk.
REQ-006 SHALL have port op  input  4  operation select, sampled with start.
REQ-007 SHALL have port a  input  WIDTH  operand A; the only operand for NOT, NEG and the shift/rotate value.
REQ-008 SHALL have port b  input  WIDTH  operand B; the shift amount is b[SHAMT_W-1:0], upper bits ignored.
REQ-009 SHALL have port c  output  WIDTH  registered result.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle shift is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port zero  output  1  registered flag, c == 0.
REQ-013 SHALL have port err  output  1  registered flag, last completed op was illegal.

Function
REQ-014 op encoding SHALL be: 0 AND, 1 OR, 2 NOT (~a), 3 NEG (two's complement of a, mod 2^WIDTH), 4 SHL, 5 SHR (logical), 6 SHRA (arithmetic), 7 ROL, 8 ROR; 9-15 illegal.
REQ-015 The FSM SHALL have states IDLE and SHIFT only.
REQ-016 In IDLE, start=1 with op in {0-3} SHALL update c, zero and err=0 on the same edge and pulse done for the following cycle (latency 1); state stays IDLE.
REQ-017 In IDLE, start=1 with op in {4-8} and amount k=0 SHALL complete as in REQ-016 with c=a.
REQ-018 In IDLE, start=1 with op in {4-8} and k>0 SHALL latch a into a working register and k into a down-counter, latch op, and enter SHIFT; busy SHALL be 1 from the next cycle.
REQ-019 In SHIFT, each edge SHALL shift/rotate the working register by exactly one bit and decrement the counter; SHRA SHALL replicate the MSB, SHL/SHR SHALL insert 0, ROL/ROR SHALL wrap the exiting bit.
REQ-020 On the edge where the counter reaches 0, the working value SHALL be written to c, zero updated, err=0, done pulsed for the following cycle, busy cleared, state returned to IDLE; total latency = k cycles from the start edge.
REQ-021 Illegal op with start in IDLE SHALL set c=0, zero=1, err=1 and pulse done with latency 1.
REQ-022 start asserted while busy=1 (including the completion edge) SHALL be ignored with no queuing; c changes only on completion.
REQ-023 c, zero and err SHALL hold their values between completions; done SHALL never be high for two consecutive cycles unless two back-to-back latency-1 requests are issued.
REQ-024 Maximum latency SHALL be WIDTH-1 cycles (k = WIDTH-1).
REQ-025 Changes on a, b, op after the start edge SHALL not affect an in-progress shift.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=IDLE, c=0, zero=1, err=0, busy=0, done=0, counter=0, working register=0.
REQ-027 Reset asserted mid-shift SHALL abort the operation with no done pulse after release.
REQ-028 The first start SHALL be accepted on the first rising edge with reset_n=1.

Verification (WIDTH=32)
REQ-029 AND, a=0xF0F0_F0F0, b=0xFF00_FF00, start 1 cycle -> c=0xF000_F000, done 1 cycle later, busy never high.
REQ-030 NEG, a=0x0000_0001 -> c=0xFFFF_FFFF, zero=0; NEG a=0 -> c=0, zero=1.
REQ-031 SHRA, a=0x8000_0000, b=4 -> busy high 3 cycles, done 4 cycles after start edge, c=0xF800_0000; ROL a=0x8000_0001, b=1 -> c=0x0000_0003, latency 1.
REQ-032 SHR a=0xFFFF_FFFF, b=31, second start (AND) issued at cycle 5 -> second start ignored, c=0x0000_0001 at cycle 31, single done pulse.
REQ-033 SHL a=0x1, b=16, reset_n pulsed low at cycle 8 -> c=0, busy=0, no done; subsequent op=12 -> c=0, err=1, done latency 1.
